// File: rtl/fp_mult_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fp_mult_pipe
// Brief    : Parametrised pipelined IEEE-754 multiplier with RNE rounding and
//            flush-to-zero. Define FPM_EXC_FLAGS_EN to add the 4-bit
//            {invalid, overflow, underflow, inexact} flags output.
// Revision : 1.0 - initial release
// ============================================================================
module fp_mult_pipe #(
    parameter int EXP_WIDTH      = 8,
    parameter int MANTISSA_WIDTH = 23,
    parameter int WIDTH          = 1 + EXP_WIDTH + MANTISSA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result
`ifdef FPM_EXC_FLAGS_EN
    ,
    output logic [3:0]       flags
`endif
);

    localparam int c_sw = MANTISSA_WIDTH + 1;
    localparam int c_pw = 2 * c_sw;
    localparam int c_xw = EXP_WIDTH + 2;
    localparam logic signed [c_xw-1:0]  c_bias  = c_xw'((1 << (EXP_WIDTH - 1)) - 1);
    localparam logic signed [c_xw-1:0]  c_emax  = c_xw'((1 << EXP_WIDTH) - 1);
    localparam logic signed [c_xw-1:0]  c_ezero = '0;
    localparam logic [EXP_WIDTH-1:0]    c_ones  = '1;
    localparam logic [WIDTH-1:0]        c_qnan  = {1'b0, c_ones, 1'b1, {(MANTISSA_WIDTH-1){1'b0}}};

    logic                   r_out_valid;
    logic [WIDTH-1:0]       r_result;
    logic                   w_adv;

    // The whole pipe, bubbles included, moves only when the output slot frees.
    assign w_adv     = !r_out_valid || out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_out_valid;
    assign result    = r_result;

    logic                   r0_valid;
    logic [WIDTH-1:0]       r0_a;
    logic [WIDTH-1:0]       r0_b;

    logic [EXP_WIDTH-1:0]      w_ea;
    logic [EXP_WIDTH-1:0]      w_eb;
    logic [MANTISSA_WIDTH-1:0] w_fa;
    logic [MANTISSA_WIDTH-1:0] w_fb;
    logic w_a_zero, w_a_inf, w_a_nan;
    logic w_b_zero, w_b_inf, w_b_nan;
    logic w_nan, w_inf, w_zero;
    logic signed [c_xw-1:0] w_exp_sum;

    assign w_ea = r0_a[WIDTH-2 -: EXP_WIDTH];
    assign w_eb = r0_b[WIDTH-2 -: EXP_WIDTH];
    assign w_fa = r0_a[MANTISSA_WIDTH-1:0];
    assign w_fb = r0_b[MANTISSA_WIDTH-1:0];

    // Subnormal inputs count as zero.
    assign w_a_zero = (w_ea == '0);
    assign w_b_zero = (w_eb == '0);
    assign w_a_inf  = (w_ea == c_ones) && (w_fa == '0);
    assign w_b_inf  = (w_eb == c_ones) && (w_fb == '0);
    assign w_a_nan  = (w_ea == c_ones) && (w_fa != '0);
    assign w_b_nan  = (w_eb == c_ones) && (w_fb != '0);

    assign w_nan  = w_a_nan || w_b_nan || (w_a_zero && w_b_inf) || (w_a_inf && w_b_zero);
    assign w_inf  = w_a_inf || w_b_inf;
    assign w_zero = w_a_zero || w_b_zero;
    assign w_exp_sum = c_xw'(w_ea) + c_xw'(w_eb) - c_bias;

    logic                   r1_valid;
    logic                   r1_sign, r1_nan, r1_inf, r1_zero;
    logic signed [c_xw-1:0] r1_exp;
    logic [c_sw-1:0]        r1_sa;
    logic [c_sw-1:0]        r1_sb;

    logic                   r2_valid;
    logic                   r2_sign, r2_nan, r2_inf, r2_zero;
    logic signed [c_xw-1:0] r2_exp;
    logic [c_pw-1:0]        r2_prod;

    logic [c_pw-1:0]           w_norm;
    logic [c_sw-1:0]           w_sig;
    logic                      w_guard, w_sticky, w_inc, w_carry;
    logic [c_sw:0]             w_rnd;
    logic [MANTISSA_WIDTH-1:0] w_frac;
    logic signed [c_xw-1:0]    w_exp_fin;
    logic                      w_ovf, w_unf;
    logic [WIDTH-1:0]          w_res;

    // Product of two [1,2) significands lies in [1,4); align to a leading one.
    assign w_norm   = r2_prod[c_pw-1] ? r2_prod : {r2_prod[c_pw-2:0], 1'b0};
    assign w_sig    = w_norm[c_pw-1 -: c_sw];
    assign w_guard  = w_norm[c_pw-1-c_sw];
    assign w_sticky = |w_norm[c_pw-2-c_sw:0];
    assign w_inc    = w_guard && (w_sticky || w_sig[0]);
    assign w_rnd    = {1'b0, w_sig} + {{c_sw{1'b0}}, w_inc};
    assign w_carry  = w_rnd[c_sw];
    assign w_frac   = w_carry ? w_rnd[MANTISSA_WIDTH:1] : w_rnd[MANTISSA_WIDTH-1:0];
    assign w_exp_fin = r2_exp + c_xw'(r2_prod[c_pw-1]) + c_xw'(w_carry);
    assign w_ovf    = (w_exp_fin >= c_emax);
    assign w_unf    = (w_exp_fin <= c_ezero);

    always_comb begin
        w_res = '0;
        if (r2_nan) begin
            w_res = c_qnan;
        end else if (r2_inf) begin
            w_res = {r2_sign, c_ones, {MANTISSA_WIDTH{1'b0}}};
        end else if (r2_zero) begin
            w_res = {r2_sign, {(WIDTH-1){1'b0}}};
        end else if (w_ovf) begin
            w_res = {r2_sign, c_ones, {MANTISSA_WIDTH{1'b0}}};
        end else if (w_unf) begin
            w_res = {r2_sign, {(WIDTH-1){1'b0}}};
        end else begin
            w_res = {r2_sign, w_exp_fin[EXP_WIDTH-1:0], w_frac};
        end
    end

`ifdef FPM_EXC_FLAGS_EN
    logic [3:0] r_flags;
    logic [3:0] w_flg;

    assign flags = r_flags;

    always_comb begin
        w_flg = 4'b0000;
        if (r2_nan) begin
            w_flg = 4'b1000;
        end else if (r2_inf || r2_zero) begin
            w_flg = 4'b0000;
        end else if (w_ovf) begin
            w_flg = 4'b0101;
        end else if (w_unf) begin
            w_flg = 4'b0011;
        end else begin
            w_flg = {3'b000, w_guard || w_sticky};
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r0_valid    <= 1'b0;
            r1_valid    <= 1'b0;
            r2_valid    <= 1'b0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
`ifdef FPM_EXC_FLAGS_EN
            r_flags     <= 4'b0000;
`endif
        end else if (w_adv) begin
            r0_valid    <= in_valid;
            r1_valid    <= r0_valid;
            r2_valid    <= r1_valid;
            r_out_valid <= r2_valid;
            if (r2_valid) begin
                r_result <= w_res;
`ifdef FPM_EXC_FLAGS_EN
                r_flags  <= w_flg;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_adv) begin
            r0_a    <= a;
            r0_b    <= b;
            r1_sign <= r0_a[WIDTH-1] ^ r0_b[WIDTH-1];
            r1_nan  <= w_nan;
            r1_inf  <= w_inf;
            r1_zero <= w_zero;
            r1_exp  <= w_exp_sum;
            r1_sa   <= {1'b1, w_fa};
            r1_sb   <= {1'b1, w_fb};
            r2_sign <= r1_sign;
            r2_nan  <= r1_nan;
            r2_inf  <= r1_inf;
            r2_zero <= r1_zero;
            r2_exp  <= r1_exp;
            r2_prod <= c_pw'(r1_sa) * c_pw'(r1_sb);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_mult_pipe.sv
`default_nettype none
// Bench for fp_mult_pipe: single and half precision instances checked against
// an integer-arithmetic reference model through per-instance scoreboards.
module tb_fp_mult_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [31:0] s_a, s_b, s_result;
    logic [3:0]  s_flags;
    logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready;
    logic [15:0] h_a, h_b, h_result;
    logic [3:0]  h_flags;

    fp_mult_pipe u_sp (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .a(s_a), .b(s_b), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .result(s_result)
`ifdef FPM_EXC_FLAGS_EN
        , .flags(s_flags)
`endif
    );

    fp_mult_pipe #(.EXP_WIDTH(5), .MANTISSA_WIDTH(10)) u_hp (
        .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready),
        .a(h_a), .b(h_b), .out_valid(h_out_valid), .out_ready(h_out_ready),
        .result(h_result)
`ifdef FPM_EXC_FLAGS_EN
        , .flags(h_flags)
`endif
    );

`ifndef FPM_EXC_FLAGS_EN
    assign s_flags = 4'b0000;
    assign h_flags = 4'b0000;
`endif

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flg;
        int          acc;
        int          stl;
    } exp_t;

    exp_t sq[$];
    exp_t hq[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   stalls  = 0;
    int   s_emitted = 0;
    bit   s_shown = 0;
    bit   s_held_v = 0;
    logic [31:0] s_held;
    bit   rnd_done;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic fail_msg(input string nm, input string what);
        n_tests++;
        n_fail++;
        $display("FAIL %s: %s (cycle %0d)", nm, what, cyc);
    endtask

    // Reference: exact integer product, then round by comparing the discarded
    // remainder against one half ulp; returns {flags, result}.
    function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input int E, input int M);
        longint ones, ea, eb, fa, fb, p, q, rem, half, r;
        int     e, sh;
        logic   s, az, ai, an, bz, bi, bn;
        logic [3:0] f;
        ones = (longint'(1) << E) - 1;
        s  = a[E+M] ^ b[E+M];
        ea = (longint'(a) >> M) & ones;
        eb = (longint'(b) >> M) & ones;
        fa = longint'(a) & ((longint'(1) << M) - 1);
        fb = longint'(b) & ((longint'(1) << M) - 1);
        az = (ea == 0); ai = (ea == ones) && (fa == 0); an = (ea == ones) && (fa != 0);
        bz = (eb == 0); bi = (eb == ones) && (fb == 0); bn = (eb == ones) && (fb != 0);
        f = 4'b0000;
        if (an || bn || (az && bi) || (ai && bz)) begin
            r = (ones << M) | (longint'(1) << (M - 1));
            f = 4'b1000;
        end else if (ai || bi) begin
            r = (longint'(s) << (E + M)) | (ones << M);
        end else if (az || bz) begin
            r = longint'(s) << (E + M);
        end else begin
            p = (fa | (longint'(1) << M)) * (fb | (longint'(1) << M));
            e = int'(ea + eb) - int'(ones >> 1);
            sh = M;
            if (p >= (longint'(1) << (2 * M + 1))) begin
                sh = M + 1;
                e++;
            end
            q    = p >> sh;
            rem  = p - (q << sh);
            half = longint'(1) << (sh - 1);
            if (rem > half || (rem == half && q[0])) q++;
            if (q == (longint'(1) << (M + 1))) begin
                q = q >> 1;
                e++;
            end
            if (e >= ones) begin
                r = (longint'(s) << (E + M)) | (ones << M);
                f = 4'b0101;
            end else if (e <= 0) begin
                r = longint'(s) << (E + M);
                f = 4'b0011;
            end else begin
                r = (longint'(s) << (E + M)) | (longint'(e) << M) | (q & ((longint'(1) << M) - 1));
                f = {3'b000, rem != 0};
            end
        end
        return {f, r[31:0]};
    endfunction

    function automatic logic [31:0] rnd_op(input int E, input int M);
        logic [31:0] x, ones;
        int k, ex;
        x = $urandom;
        if (E + M + 1 < 32) x = x & ((32'h1 << (E + M + 1)) - 1);
        ones = (32'h1 << E) - 1;
        k  = $urandom % 10;
        ex = -1;
        case (k)
            0: ex = 0;
            1: ex = int'(ones);
            2: ex = $urandom_range(1, 3);
            3: ex = int'(ones) - $urandom_range(1, 3);
            4: ex = int'(ones >> 1) + $urandom_range(0, 2) - 1;
            default: ;
        endcase
        if (ex >= 0) x = (x & ~(ones << M)) | (32'(ex) << M);
        if (k == 1 && ($urandom % 2) == 1) x = x & ~((32'h1 << M) - 1);
        if (k == 5) x = x | ((32'h1 << M) - 1);
        return x;
    endfunction

    // Single-precision scoreboard: handshake rule, stall stability, order, latency.
    always @(negedge clk) begin
        if (rst) begin
            sq.delete();
            s_shown  = 0;
            s_held_v = 0;
        end else begin
            chk("in_ready_rule", s_in_ready, !s_out_valid || s_out_ready);
            if (s_held_v) begin
                chk("stall_valid", s_out_valid, 1);
                chk("stall_stable", s_result, s_held);
            end
            if (s_out_valid) begin
                if (sq.size() == 0) begin
                    fail_msg("sp_spurious", "result with no outstanding operation");
                end else begin
                    if (!s_shown) begin
                        s_shown = 1;
                        if (sq[0].stl == stalls) chk("sp_latency", cyc - sq[0].acc, 3);
                    end
                    if (s_out_ready) begin
                        chk("sp_result", s_result, sq[0].res);
`ifdef FPM_EXC_FLAGS_EN
                        chk("sp_flags", s_flags, sq[0].flg);
`endif
                        void'(sq.pop_front());
                        s_emitted++;
                        s_shown  = 0;
                        s_held_v = 0;
                    end else begin
                        s_held   = s_result;
                        s_held_v = 1;
                        stalls++;
                    end
                end
            end
            if (s_in_valid && s_in_ready) begin
                logic [35:0] m;
                m = model(s_a, s_b, 8, 23);
                sq.push_back('{res: m[31:0], flg: m[35:32], acc: cyc + 1, stl: stalls});
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            hq.delete();
        end else begin
            if (h_out_valid) begin
                if (hq.size() == 0) begin
                    fail_msg("hp_spurious", "result with no outstanding operation");
                end else begin
                    chk("hp_latency", cyc - hq[0].acc, 3);
                    chk("hp_result", {16'h0, h_result}, hq[0].res);
`ifdef FPM_EXC_FLAGS_EN
                    chk("hp_flags", h_flags, hq[0].flg);
`endif
                    void'(hq.pop_front());
                end
            end
            if (h_in_valid && h_in_ready) begin
                logic [35:0] m;
                m = model({16'h0, h_a}, {16'h0, h_b}, 5, 10);
                hq.push_back('{res: m[31:0], flg: m[35:32], acc: cyc + 1, stl: 0});
            end
        end
    end

    task automatic send_s(input logic [31:0] a, input logic [31:0] b);
        int  t;
        bit  ok;
        t = 0;
        ok = 0;
        s_a = a;
        s_b = b;
        s_in_valid = 1'b1;
        while (!ok) begin
            @(negedge clk);
            ok = s_in_ready;
            @(posedge clk);
            #1;
            t++;
            if (!ok && t > 100) begin
                fail_msg("sp_accept_timeout", "operand never accepted");
                break;
            end
        end
        s_in_valid = 1'b0;
    endtask

    task automatic send_h(input logic [15:0] a, input logic [15:0] b);
        int  t;
        bit  ok;
        t = 0;
        ok = 0;
        h_a = a;
        h_b = b;
        h_in_valid = 1'b1;
        while (!ok) begin
            @(negedge clk);
            ok = h_in_ready;
            @(posedge clk);
            #1;
            t++;
            if (!ok && t > 100) begin
                fail_msg("hp_accept_timeout", "operand never accepted");
                break;
            end
        end
        h_in_valid = 1'b0;
    endtask

    task automatic lit_s(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input logic [3:0] flg);
        logic [35:0] m;
        m = model(a, b, 8, 23);
        chk("model_sp_res", m[31:0], res);
        chk("model_sp_flags", m[35:32], flg);
        send_s(a, b);
    endtask

    task automatic lit_h(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] res, input logic [3:0] flg);
        logic [35:0] m;
        m = model({16'h0, a}, {16'h0, b}, 5, 10);
        chk("model_hp_res", m[31:0], {16'h0, res});
        chk("model_hp_flags", m[35:32], flg);
        send_h(a, b);
    endtask

    task automatic drain;
        int t;
        t = 0;
        while ((sq.size() != 0 || hq.size() != 0) && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (sq.size() != 0 || hq.size() != 0) fail_msg("drain", "results still outstanding");
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        fail_msg("watchdog", "time limit reached before completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        s_in_valid = 1'b0; s_a = '0; s_b = '0; s_out_ready = 1'b1;
        h_in_valid = 1'b0; h_a = '0; h_b = '0; h_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_sp_out_valid", s_out_valid, 0);
        chk("rst_sp_result", s_result, 0);
        chk("rst_sp_in_ready", s_in_ready, 1);
        chk("rst_hp_out_valid", h_out_valid, 0);
        chk("rst_hp_in_ready", h_in_ready, 1);
`ifdef FPM_EXC_FLAGS_EN
        chk("rst_sp_flags", s_flags, 0);
`endif
        @(posedge clk);
        #1;

        lit_s(32'h40000000, 32'h40400000, 32'h40C00000, 4'b0000);
        lit_s(32'h3FC00000, 32'h3FC00000, 32'h40100000, 4'b0000);
        lit_s(32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001);
        lit_s(32'h00000000, 32'h7F800000, 32'h7FC00000, 4'b1000);
        lit_s(32'hBF800000, 32'h7F800000, 32'hFF800000, 4'b0000);
        lit_s(32'h7F000000, 32'h40000000, 32'h7F800000, 4'b0101);
        lit_s(32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011);
        lit_s(32'h3FFFFFFF, 32'h3F800001, 32'h40000000, 4'b0001);
        drain;

        // Backpressure: five back-to-back pairs, four-cycle stall on first result.
        begin
            int base;
            base = s_emitted;
            fork
                begin
                    for (int i = 0; i < 5; i++) send_s(rnd_op(8, 23), rnd_op(8, 23));
                end
                begin
                    int t;
                    t = 0;
                    @(negedge clk);
                    while (!s_out_valid && t < 50) begin
                        @(negedge clk);
                        t++;
                    end
                    @(posedge clk);
                    #1;
                    s_out_ready = 1'b0;
                    repeat (4) @(posedge clk);
                    #1;
                    s_out_ready = 1'b1;
                end
            join
            drain;
            chk("bp_emitted", s_emitted - base, 5);
        end

        // Reset while two operations are in flight.
        send_s(32'h40000000, 32'h40400000);
        send_s(32'h3FC00000, 32'h3FC00000);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst_flush_valid", s_out_valid, 0);
        end
        chk("rst_flush_in_ready", s_in_ready, 1);
        @(posedge clk);
        #1;
        lit_s(32'h40000000, 32'h40400000, 32'h40C00000, 4'b0000);
        drain;

        lit_h(16'h4000, 16'h4200, 16'h4600, 4'b0000);
        lit_h(16'h7BFF, 16'h4000, 16'h7C00, 4'b0101);
        for (int i = 0; i < 40; i++) begin
            logic [31:0] x, y;
            x = rnd_op(5, 10);
            y = rnd_op(5, 10);
            send_h(x[15:0], y[15:0]);
        end
        drain;

        rnd_done = 0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    send_s(rnd_op(8, 23), rnd_op(8, 23));
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                end
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    s_out_ready = ($urandom % 4) != 0;
                end
                s_out_ready = 1'b1;
            end
        join
        drain;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fp_mult_pipe.md
Name: fp_mult_pipe

Overview:
Parametrised, pipelined floating-point multiplier. Generalises the fixed single-precision multiplier to any exponent/mantissa width, e.g. half, single or double precision.
- Fixed 3-stage pipeline with valid/ready handshakes on both sides.
- Round-to-nearest-even rounding.
- IEEE-754 special-value handling: zero, infinity, NaN.
- Sits between the operand-issue logic and the result writeback, and is driven by the existing class-based bench.

Parameters:
EXP_WIDTH, 8, exponent field width (>=4).
MANTISSA_WIDTH, 23, stored fraction width, without the hidden bit (>=4).
WIDTH, 1+EXP_WIDTH+MANTISSA_WIDTH, derived operand/result width; not overridden.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  operands a/b valid.
in_ready  out  1  block accepts operands this cycle.
a  in  WIDTH  operand A (sign|exp|fraction).
b  in  WIDTH  operand B.
out_valid  out  1  result valid.
out_ready  in  1  downstream accepts result.
result  out  WIDTH  product.

Behaviour:
Reset and handshake
- Reset: all stage valid bits clear. out_valid=0, result=0. in_ready=1 in the cycle after reset deasserts.
- Reset mid-operation discards all in-flight operations. No result is emitted for them.
- Global advance: adv = !out_valid || out_ready. in_ready = adv.
- Input transfer occurs on in_valid && in_ready.
- When adv=0 the whole pipeline holds, including bubbles.
- While out_valid=1 && out_ready=0, result is stable.
- Latency: an operand accepted at edge N gives out_valid=1 after edge N+3, provided no stall occurs.
- Throughput: 1 per cycle under continuous out_ready=1.

Stage 1 (unpack/classify)
- Sign = sa^sb. Bias = 2^(EXP_WIDTH-1)-1.
- Classify each operand:
  - zero: exp=0. Subnormals are flushed to zero.
  - inf: exp all-ones, fraction 0.
  - NaN: exp all-ones, fraction !=0.
- Exponent sum = ea+eb-bias, computed signed in EXP_WIDTH+2 bits.

Stage 2 (multiply)
- Multiply the (MANTISSA_WIDTH+1)-bit significands, hidden bit = 1, to give a 2*(MANTISSA_WIDTH+1)-bit product.
- Class flags and exponent sum are piped alongside.

Stage 3 (normalise/round/pack)
- If product MSB = 1: shift right 1 and exponent+1.
- Keep MANTISSA_WIDTH fraction bits. Guard = next bit. Sticky = OR of the remaining bits.
- RNE: increment when guard && (sticky || lsb).
- If the increment carries out of the significand: renormalise and exponent+1.
- Final exponent >= all-ones: result = signed infinity {sign, all-ones, 0}.
- Final exponent <= 0: result = signed zero (flush).

Special-value priority (highest first)
1. Either operand NaN, or zero*inf: canonical quiet NaN = {0, all-ones, 1, zeros}.
2. Either operand inf: signed inf.
3. Either operand zero: signed zero.
4. Otherwise: normal path.

Optional Feature:
Macro FPM_EXC_FLAGS_EN.
- Defined: adds output port flags, width 4, {invalid, overflow, underflow, inexact}, aligned with result and valid when out_valid=1.
  - invalid: a NaN result from rule 1.
  - overflow: normal path saturated to inf.
  - underflow: normal path flushed to zero with a nonzero exact product.
  - inexact: guard|sticky was set on the normal path, or overflow, or underflow.
  - Reset value 0. Held stable during a stall.
- Not defined: no flags port and no flag logic. Datapath and timing are identical in both builds.

Test Plan:
1. Defaults, out_ready=1: a=0x40000000 (2.0), b=0x40400000 (3.0) -> result=0x40C00000 exactly 3 cycles after acceptance. Also a=0x3FC00000, b=0x3FC00000 -> 0x40100000.
2. RNE: a=b=0x3F800001 -> 0x3F800002, with flags=0001 when FPM_EXC_FLAGS_EN is defined.
3. Specials:
   - 0x00000000*0x7F800000 -> 0x7FC00000, invalid.
   - 0xBF800000*0x7F800000 -> 0xFF800000.
   - 0x7F000000*0x40000000 -> 0x7F800000, overflow.
   - 0x00800000*0x3F000000 -> 0x00000000, underflow.
4. Backpressure: stream 5 operand pairs back-to-back and hold out_ready=0 for 4 cycles once out_valid rises. Required: in_ready=0 during the stall, result stable, all 5 results emitted in order with none lost or duplicated.
5. Reset mid-flight: accept 2 operations, assert rst for 1 cycle before the first completes. Required: out_valid stays 0 afterwards; the next operation (2.0*3.0) completes normally with 3-cycle latency.
6. Half precision (EXP_WIDTH=5, MANTISSA_WIDTH=10): 0x4000*0x4200 -> 0x4600. 0x7BFF*0x4000 -> 0x7C00.
